// File: rtl/pid_pkg.sv
// Shared types and fixed-point helpers for the multi-channel PID controller.
// Helpers work on 64-bit signed values so callers can pass any narrower width.
package pid_pkg;

    typedef enum logic [1:0] {IDLE, ERR, MUL, SUM} pid_state_t;

    function automatic int gain_w(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    function automatic longint smax(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint smin(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    function automatic longint clamp(input longint v, input longint lim);
        if (v > lim)
            return lim;
        else if (v < -lim)
            return -lim;
        return v;
    endfunction

    function automatic longint saturate(input longint v, input int w);
        if (v > smax(w))
            return smax(w);
        else if (v < smin(w))
            return smin(w);
        return v;
    endfunction

endpackage

// File: rtl/pid_datapath.sv
// ERR/MUL/SUM arithmetic for the channel slot currently selected by the top FSM.
// Pipeline registers hold data only; the FSM decides when each stage is captured.
module pid_datapath
    import pid_pkg::*;
#(
    parameter int     PV_WIDTH       = 9,
    parameter int     PID_FRAC_WIDTH = 8,
    parameter int     GAIN_W         = 13,
    parameter int     CONTROL_WIDTH  = 17,
    parameter int     INT_WIDTH      = 16,
    parameter longint INT_LIMIT      = 32767
) (
    input  logic                     clk,
    input  logic                     vld_p0,
    input  logic                     vld_p1,
    input  logic [PV_WIDTH-1:0]      sp,
    input  logic [PV_WIDTH-1:0]      fb,
    input  logic [GAIN_W-1:0]        kp,
    input  logic [GAIN_W-1:0]        ki,
    input  logic [GAIN_W-1:0]        kd,
    input  logic [PV_WIDTH:0]        prev_err,
    input  logic [INT_WIDTH-1:0]     integ,
    input  logic                     hold_hi,
    input  logic                     hold_lo,
    output logic [PV_WIDTH:0]        err_p0,
    output logic [INT_WIDTH-1:0]     integ_p0,
    output logic [CONTROL_WIDTH-1:0] ctrl,
    output logic                     clip_hi,
    output logic                     clip_lo
);

    localparam int P_W = GAIN_W + 1 + ((INT_WIDTH > PV_WIDTH + 2) ? INT_WIDTH : PV_WIDTH + 2);
    localparam int S_W = P_W + 2;

    logic signed [PV_WIDTH:0]    e, e_p0;
    logic signed [PV_WIDTH+1:0]  d, d_p0;
    logic signed [INT_WIDTH-1:0] i_prev, i_new, i_p0;
    logic                        e_pos, e_neg;
    longint                      i_cand;

    // ERR: error, derivative and anti-windup integrator candidate
    assign e      = $signed({1'b0, sp}) - $signed({1'b0, fb});
    assign d      = $signed({e[PV_WIDTH], e}) - $signed({prev_err[PV_WIDTH], prev_err});
    assign i_prev = $signed(integ);
    assign e_neg  = e[PV_WIDTH];
    assign e_pos  = !e[PV_WIDTH] && (e != '0);

    always_comb begin
        i_cand = clamp(64'(i_prev) + 64'(e), INT_LIMIT);
        i_new  = INT_WIDTH'(i_cand);
        if ((hold_hi && e_pos) || (hold_lo && e_neg))
            i_new = i_prev;
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            e_p0 <= e;
            d_p0 <= d;
            i_p0 <= i_new;
        end
    end

    assign err_p0   = e_p0;
    assign integ_p0 = i_p0;

    // MUL: gains are zero-extended so every product is a signed full-precision term
    logic signed [P_W-1:0] pp_p1, pi_p1, pd_p1;

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            pp_p1 <= P_W'($signed({1'b0, kp})) * P_W'(e_p0);
            pi_p1 <= P_W'($signed({1'b0, ki})) * P_W'(i_p0);
            pd_p1 <= P_W'($signed({1'b0, kd})) * P_W'(d_p0);
        end
    end

    // SUM: floor-shift back to integer units, then saturate to the output range
    logic signed [S_W-1:0] s, s_sh;

    assign s       = S_W'(pp_p1) + S_W'(pi_p1) + S_W'(pd_p1);
    assign s_sh    = s >>> PID_FRAC_WIDTH;
    assign ctrl    = CONTROL_WIDTH'(saturate(64'(s_sh), CONTROL_WIDTH));
    assign clip_hi = 64'(s_sh) > smax(CONTROL_WIDTH);
    assign clip_lo = 64'(s_sh) < smin(CONTROL_WIDTH);

endmodule

// File: rtl/pid_controller_mc.sv
// Time-multiplexed PID controller: one shared datapath visits each channel in turn
// (ERR, MUL, SUM per channel) after a start request, then pulses done.
module pid_controller_mc
    import pid_pkg::*;
#(
    parameter int     N_CH           = 2,
    parameter int     PV_WIDTH       = 9,
    parameter int     PID_FRAC_WIDTH = 8,
    parameter int     GAIN_INT_WIDTH = 5,
    parameter int     CONTROL_WIDTH  = 17,
    parameter int     INT_WIDTH      = 16,
    parameter longint INT_LIMIT      = (longint'(1) <<< (INT_WIDTH - 1)) - 1
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               clk_en,
    input  logic                                               en,
    input  logic                                               start,
    input  logic [N_CH*(GAIN_INT_WIDTH+PID_FRAC_WIDTH)-1:0]    k_p,
    input  logic [N_CH*(GAIN_INT_WIDTH+PID_FRAC_WIDTH)-1:0]    k_i,
    input  logic [N_CH*(GAIN_INT_WIDTH+PID_FRAC_WIDTH)-1:0]    k_d,
    input  logic [N_CH*PV_WIDTH-1:0]                           setpoint,
    input  logic [N_CH*PV_WIDTH-1:0]                           feedback,
    output logic                                               busy,
    output logic                                               done,
    output logic [N_CH*CONTROL_WIDTH-1:0]                      control_signal_out,
    output logic [N_CH-1:0]                                    sat
);

    localparam int GAIN_W = gain_w(GAIN_INT_WIDTH, PID_FRAC_WIDTH);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    pid_state_t              state_q, state_d;
    logic [CH_W-1:0]         ch_q;
    logic                    done_q, last, accept, clear;

    logic [PV_WIDTH-1:0]      sp_q [N_CH];
    logic [PV_WIDTH-1:0]      fb_q [N_CH];
    logic [GAIN_W-1:0]        kp_q [N_CH];
    logic [GAIN_W-1:0]        ki_q [N_CH];
    logic [GAIN_W-1:0]        kd_q [N_CH];
    logic [INT_WIDTH-1:0]     integ_q [N_CH];
    logic [PV_WIDTH:0]        perr_q [N_CH];
    logic [CONTROL_WIDTH-1:0] ctrl_q [N_CH];
    logic [N_CH-1:0]          sat_q, sat_hi_q, sat_lo_q;

    logic [PV_WIDTH:0]        err_p0;
    logic [INT_WIDTH-1:0]     integ_p0;
    logic [CONTROL_WIDTH-1:0] ctrl;
    logic                     clip_hi, clip_lo;

    assign last   = (ch_q == CH_W'(N_CH - 1));
    assign accept = (state_q == IDLE) && start && en;
    assign clear  = reset || (clk_en && !en);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ERR;
            ERR:     state_d = MUL;
            MUL:     state_d = SUM;
            SUM:     state_d = last ? IDLE : ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            done_q  <= (state_q == SUM) && last;
            if (state_q == IDLE)
                ch_q <= '0;
            else if (state_q == SUM && !last)
                ch_q <= ch_q + CH_W'(1);
        end
    end

    // Sample capture: inputs are frozen for the whole sequence
    always_ff @(posedge clk) begin
        if (clk_en && accept) begin
            for (int c = 0; c < N_CH; c++) begin
                sp_q[c] <= setpoint[c*PV_WIDTH +: PV_WIDTH];
                fb_q[c] <= feedback[c*PV_WIDTH +: PV_WIDTH];
                kp_q[c] <= k_p[c*GAIN_W +: GAIN_W];
                ki_q[c] <= k_i[c*GAIN_W +: GAIN_W];
                kd_q[c] <= k_d[c*GAIN_W +: GAIN_W];
            end
        end
    end

    // Per-channel writeback at the end of each channel's SUM cycle
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int c = 0; c < N_CH; c++) begin
                integ_q[c] <= '0;
                perr_q[c]  <= '0;
                ctrl_q[c]  <= '0;
            end
            sat_q    <= '0;
            sat_hi_q <= '0;
            sat_lo_q <= '0;
        end else if (clk_en && state_q == SUM) begin
            integ_q[ch_q]  <= integ_p0;
            perr_q[ch_q]   <= err_p0;
            ctrl_q[ch_q]   <= ctrl;
            sat_hi_q[ch_q] <= clip_hi;
            sat_lo_q[ch_q] <= clip_lo;
            sat_q[ch_q]    <= clip_hi | clip_lo;
        end
    end

    pid_datapath #(
        .PV_WIDTH       (PV_WIDTH),
        .PID_FRAC_WIDTH (PID_FRAC_WIDTH),
        .GAIN_W         (GAIN_W),
        .CONTROL_WIDTH  (CONTROL_WIDTH),
        .INT_WIDTH      (INT_WIDTH),
        .INT_LIMIT      (INT_LIMIT)
    ) u_datapath (
        .clk      (clk),
        .vld_p0   (clk_en && state_q == ERR),
        .vld_p1   (clk_en && state_q == MUL),
        .sp       (sp_q[ch_q]),
        .fb       (fb_q[ch_q]),
        .kp       (kp_q[ch_q]),
        .ki       (ki_q[ch_q]),
        .kd       (kd_q[ch_q]),
        .prev_err (perr_q[ch_q]),
        .integ    (integ_q[ch_q]),
        .hold_hi  (sat_hi_q[ch_q]),
        .hold_lo  (sat_lo_q[ch_q]),
        .err_p0   (err_p0),
        .integ_p0 (integ_p0),
        .ctrl     (ctrl),
        .clip_hi  (clip_hi),
        .clip_lo  (clip_lo)
    );

    for (genvar c = 0; c < N_CH; c++) begin : g_out
        assign control_signal_out[c*CONTROL_WIDTH +: CONTROL_WIDTH] = ctrl_q[c];
    end

    assign sat  = sat_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule
